// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM states and sizing for the EX-stage multiply/divide unit.
package muldiv_pkg;

    // Native operand width of the integer datapath; one iteration per bit.
    localparam int MD_XLEN  = 32;
    localparam int MD_ITERS = MD_XLEN;

    // Decoded mult/div operation as carried in ID/EX.
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_e;

    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide.
// {acc_hi, acc_lo} is the double-width accumulator; opb is multiplicand/divisor.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] acc_hi_nxt,
    output logic [WIDTH-1:0] acc_lo_nxt
);

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    // Single combinational step; the extra top bit is the add carry or the trial sign.
    always_comb begin
        mul_sum    = {1'b0, acc_hi};
        rem_sh     = {acc_hi, acc_lo[WIDTH-1]};
        trial      = rem_sh - {1'b0, opb};
        acc_hi_nxt = acc_hi;
        acc_lo_nxt = acc_lo;
        if (acc_lo[0]) begin
            mul_sum = {1'b0, acc_hi} + {1'b0, opb};
        end
        if (is_div) begin
            // rem < divisor always holds, so WIDTH+1 bits cannot overflow the trial.
            if (!trial[WIDTH]) begin
                acc_hi_nxt = trial[WIDTH-1:0];
                acc_lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                acc_hi_nxt = rem_sh[WIDTH-1:0];
                acc_lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_hi_nxt = mul_sum[WIDTH:1];
            acc_lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU unit with HI/LO and pipeline stall.
// Operands are reduced to magnitudes on accept, iterated WIDTH times, then
// sign-corrected in FIX before HI/LO are committed.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + (2*WIDTH)'(1);
    endfunction

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;   // negate product, or quotient
    logic             neg_rem_q, neg_rem_d;   // negate remainder (dividend negative)
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;

    logic             a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    assign a_neg  = md_is_signed(op) & a[WIDTH-1];
    assign b_neg  = md_is_signed(op) & b[WIDTH-1];
    assign b_zero = (b == '0);
    assign a_mag  = a_neg ? neg_w(a) : a;
    assign b_mag  = b_neg ? neg_w(b) : b;

    assign prod_fix = neg_res_q ? neg_2w({acc_hi_q, acc_lo_q}) : {acc_hi_q, acc_lo_q};
    assign quot_fix = neg_res_q ? neg_w(acc_lo_q) : acc_lo_q;
    assign rem_fix  = neg_rem_q ? neg_w(acc_hi_q) : acc_hi_q;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div     (is_div_q),
        .acc_hi     (acc_hi_q),
        .acc_lo     (acc_lo_q),
        .opb        (opb_q),
        .acc_hi_nxt (step_hi),
        .acc_lo_nxt (step_lo)
    );

    // Next-state logic: accept in IDLE, iterate in RUN, sign-fix and commit in FIX.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        opb_d     = opb_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        case (state_q)
            IDLE: begin
                // While done is high ID/EX still holds the finishing instruction.
                if (start && !done_q) begin
                    state_d   = RUN;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    is_div_d  = md_is_div(op);
                    // Divide by zero keeps the all-ones quotient unnegated.
                    neg_res_d = (a_neg ^ b_neg) & ~(md_is_div(op) & b_zero);
                    neg_rem_d = a_neg;
                    opb_d     = b_mag;
                    acc_hi_d  = '0;
                    acc_lo_d  = a_mag;
                end
            end
            RUN: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and HI/LO registers; reset clears everything including HI/LO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opb_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            opb_q     <= opb_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
        end
    end

    // Stall covers the accept cycle as well as the whole run, released in the done cycle.
    assign stall = (state_q != IDLE) | (start & ~done_q);
    assign busy  = busy_q;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
